// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers: skid-stage states and MEM/WB payload layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_pkg;

    // MEM/WB bundle: {flags[7:0], aluCtl[3:0], ir[31:0], b[31:0], result[31:0], dest[4:0]}
    localparam int PAYLOAD_W  = 113;

    localparam int DEST_LSB   = 0;
    localparam int DEST_W     = 5;
    localparam int RESULT_LSB = DEST_LSB + DEST_W;      // 5
    localparam int RESULT_W   = 32;
    localparam int B_LSB      = RESULT_LSB + RESULT_W;  // 37
    localparam int B_W        = 32;
    localparam int IR_LSB     = B_LSB + B_W;            // 69
    localparam int IR_W       = 32;
    localparam int ALUCTL_LSB = IR_LSB + IR_W;          // 101
    localparam int ALUCTL_W   = 4;
    localparam int FLAGS_LSB  = ALUCTL_LSB + ALUCTL_W;  // 105
    localparam int FLAGS_W    = 8;

    // EMPTY: nothing held; ONE: main valid; TWO: main and skid valid
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skidState_t;

endpackage

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with optional skid entry, flush squash and saturating stall counter.
// Latency: one cycle from accept to out_valid when empty.
// Backpressure: SKID=1 registers in_ready (low only when both entries full); SKID=0 in_ready = !out_valid || out_ready.
//
// Ports: clk/rst (sync, active-high); in_valid/in_ready/in_data upstream; out_valid/out_ready/out_data
// downstream; flush drops all held entries; stall_cnt counts cycles with out_valid && !out_ready.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int             W         = PAYLOAD_W,
    parameter bit             SKID      = 1'b1,
    parameter logic [W-1:0]   RESET_VAL = '0,
    parameter int             CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    input  logic             flush,
    output logic [CNT_W-1:0] stall_cnt
);

    // Stall counter: saturates, only rst clears it (flush deliberately leaves history intact).
    logic [CNT_W-1:0] stallCnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            stallCnt <= '0;
        end else if (out_valid && !out_ready && (stallCnt != {CNT_W{1'b1}})) begin
            stallCnt <= stallCnt + CNT_W'(1);
        end
    end

    assign stall_cnt = stallCnt;

    generate
        if (SKID) begin : gSkid
            skidState_t     state;
            skidState_t     stateNext;
            logic [W-1:0]   mainQ;
            logic [W-1:0]   skidQ;
            logic           inReadyQ;
            logic           accept;
            logic           emit;
            logic           loadMainIn;
            logic           loadMainSkid;
            logic           loadSkid;

            assign accept = in_valid && inReadyQ;
            assign emit   = (state != EMPTY) && out_ready;

            always_comb begin
                stateNext    = state;
                loadMainIn   = 1'b0;
                loadMainSkid = 1'b0;
                loadSkid     = 1'b0;
                if (flush) begin
                    // Squash wins: anything accepted this cycle is dropped with the rest.
                    stateNext = EMPTY;
                end else begin
                    case (state)
                        EMPTY: begin
                            if (accept) begin
                                stateNext  = ONE;
                                loadMainIn = 1'b1;
                            end
                        end
                        ONE: begin
                            if (accept && emit) begin
                                loadMainIn = 1'b1;
                            end else if (accept) begin
                                stateNext = TWO;
                                loadSkid  = 1'b1;
                            end else if (emit) begin
                                stateNext = EMPTY;
                            end
                        end
                        TWO: begin
                            // in_ready is low here, so no accept can coincide with the refill.
                            if (emit) begin
                                stateNext    = ONE;
                                loadMainSkid = 1'b1;
                            end
                        end
                        default: stateNext = EMPTY;
                    endcase
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    state    <= EMPTY;
                    inReadyQ <= 1'b1;
                end else begin
                    state    <= stateNext;
                    // Registered from next state: breaks the out_ready -> in_ready path.
                    inReadyQ <= (stateNext != TWO);
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    mainQ <= RESET_VAL;
                    skidQ <= RESET_VAL;
                end else begin
                    if (loadMainIn) begin
                        mainQ <= in_data;
                    end else if (loadMainSkid) begin
                        mainQ <= skidQ;
                    end
                    if (loadSkid) begin
                        skidQ <= in_data;
                    end
                end
            end

            assign in_ready  = inReadyQ;
            assign out_valid = (state != EMPTY);
            assign out_data  = mainQ;
        end else begin : gSingle
            logic           validQ;
            logic [W-1:0]   mainQ;
            logic           readyComb;
            logic           accept;

            assign readyComb = !validQ || out_ready;
            assign accept    = in_valid && readyComb;

            always_ff @(posedge clk) begin
                if (rst) begin
                    validQ <= 1'b0;
                    mainQ  <= RESET_VAL;
                end else if (flush) begin
                    validQ <= 1'b0;
                end else if (accept) begin
                    validQ <= 1'b1;
                    mainQ  <= in_data;
                end else if (validQ && out_ready) begin
                    validQ <= 1'b0;
                end
            end

            assign in_ready  = readyComb;
            assign out_valid = validQ;
            assign out_data  = mainQ;
        end
    endgenerate

endmodule
